// File: rtl/masked_subbytes_ctrl.sv
// masked_subbytes_ctrl
//   Runs one SubBytes layer of a masked AES round through a single pipelined
//   DOM S-box. The 16-byte shared state is loaded on start and one byte (all
//   shares) is issued per cycle when fresh randomness is available. A
//   valid/tag shift pipe mirrors the S-box latency so that every result
//   lands back in the byte slot it came from.
//
//   Optional build macro: SBOX_IDLE_ZERO_EN
//     defined   - SboxInxDO is driven to zero on every cycle without an issue
//     undefined - SboxInxDO always shows byte[cnt], cnt saturated at 15
module masked_subbytes_ctrl #(
    parameter int unsigned SHARES  = 2,
    parameter int unsigned LATENCY = 5
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic                  StartxSI,
    input  logic [128*SHARES-1:0] DataxDI,
    input  logic                  RndValidxDI,
    output logic                  RndReqxSO,
    output logic [8*SHARES-1:0]   SboxInxDO,
    input  logic [8*SHARES-1:0]   SboxOutxDI,
    output logic [128*SHARES-1:0] DataxDO,
    output logic                  BusyxSO,
    output logic                  DonexSO
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [4:0] NUM_BYTES = 5'd16;
    localparam logic [4:0] LAST_BYTE = 5'd15;

    state_e                state_q, state_d;
    logic [4:0]            issue_cnt_q, issue_cnt_d;
    logic [4:0]            wr_cnt_q, wr_cnt_d;
    logic [LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
    logic [3:0]            pipe_tag_q [LATENCY];
    logic [3:0]            pipe_tag_d [LATENCY];
    logic [128*SHARES-1:0] data_q, data_d;

    logic       start_acc;
    logic       issue;
    logic       wb_vld;
    logic [3:0] wb_tag;
    logic [3:0] sel_idx;

    // Handshake decode shared by the FSM, the pipe and the state register.
    always_comb begin
        start_acc = StartxSI && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        issue     = (state_q == ST_ISSUE) && RndValidxDI;
        wb_vld    = pipe_vld_q[LATENCY-1];
        wb_tag    = pipe_tag_q[LATENCY-1];
        sel_idx   = issue_cnt_q[4] ? LAST_BYTE[3:0] : issue_cnt_q[3:0];
    end

    // Next-state logic and issue counter.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;

        if (start_acc) begin
            issue_cnt_d = '0;
        end else if (issue) begin
            issue_cnt_d = issue_cnt_q + 5'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Leave as soon as the 16th byte goes out so no extra request is raised.
                if (issue_cnt_d == NUM_BYTES) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Look at next-cycle values so DONE follows the final write-back directly.
                if ((wr_cnt_d == NUM_BYTES) && (pipe_vld_d == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = start_acc ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid/tag shift pipe tracking bytes in flight through the S-box.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = issue;
        pipe_tag_d[0] = issue_cnt_q[3:0];
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    // State register load on accepted start, otherwise write-back into byte[tag].
    always_comb begin
        data_d   = data_q;
        wr_cnt_d = wr_cnt_q;
        if (start_acc) begin
            data_d   = DataxDI;
            wr_cnt_d = '0;
        end else if (wb_vld) begin
            for (int unsigned s = 0; s < SHARES; s++) begin
                data_d[s*128 + 32'(wb_tag)*8 +: 8] = SboxOutxDI[s*8 +: 8];
            end
            wr_cnt_d = wr_cnt_q + 5'd1;
        end
    end

    // Registered state of the controller.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            pipe_vld_q  <= '0;
            data_q      <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            pipe_vld_q  <= pipe_vld_d;
            data_q      <= data_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= pipe_tag_d[i];
            end
        end
    end

    // Status outputs and S-box input selection.
    always_comb begin
        RndReqxSO = (state_q == ST_ISSUE);
        BusyxSO   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        DonexSO   = (state_q == ST_DONE);
        DataxDO   = data_q;
        SboxInxDO = '0;
`ifdef SBOX_IDLE_ZERO_EN
        if (issue) begin
            for (int unsigned s = 0; s < SHARES; s++) begin
                SboxInxDO[s*8 +: 8] = data_q[s*128 + 32'(sel_idx)*8 +: 8];
            end
        end
`else
        for (int unsigned s = 0; s < SHARES; s++) begin
            SboxInxDO[s*8 +: 8] = data_q[s*128 + 32'(sel_idx)*8 +: 8];
        end
`endif
    end

endmodule

// File: doc/masked_subbytes_ctrl.md
# masked_subbytes_ctrl

- Sequences one full SubBytes layer of a masked AES round through a single pipelined DOM S-box instance (`aes_sbox`, PIPELINED=1).
- Loads a 16-byte, SHARES-share state and issues one byte per cycle, throttled by fresh-randomness availability.
- Tracks in-flight bytes through the S-box pipeline and writes each result back into its original byte slot.
- Sits between the round controller and the S-box; the S-box mask/blinding inputs come directly from the PRNG and are consumed only on issue cycles.

## Interface

- `SHARES`, 2: number of Boolean shares (≥2).
- `LATENCY`, 5: S-box pipeline depth in cycles; an input presented in cycle t has its output on `SboxOutxDI` in cycle t+LATENCY (≥1).
- `ClkxCI` in 1: clock; all state on rising edge.
- `RstxBI` in 1: reset, asynchronous, active-low.
- `StartxSI` in 1: start pulse; sampled only in IDLE or DONE.
- `DataxDI` in 128*SHARES: input state; byte b of share s at `[s*128+b*8 +: 8]`; captured on the accepted start edge.
- `RndValidxDI` in 1: PRNG has a fresh S-box randomness word this cycle.
- `RndReqxSO` out 1: controller wants to issue this cycle; PRNG advances when `RndReqxSO && RndValidxDI`.
- `SboxInxDO` out 8*SHARES: S-box input; share s at `[s*8 +: 8]`.
- `SboxOutxDI` in 8*SHARES: S-box output, same layout.
- `DataxDO` out 128*SHARES: state register, same layout as `DataxDI`.
- `BusyxSO` out 1: high in ISSUE and DRAIN.
- `DonexSO` out 1: one-cycle pulse when all 16 results have been written back.

## Operation

- Reset values: state register 0, issue counter 0, valid/tag pipe 0, FSM IDLE, `RndReqxSO`/`BusyxSO`/`DonexSO` 0, `SboxInxDO` 0.
- FSM states and transitions:
  - IDLE: go to ISSUE on `StartxSI`.
  - ISSUE: go to DRAIN when issue counter reaches 16.
  - DRAIN: go to DONE when the pipe is empty and the last write-back has completed.
  - DONE: `DonexSO`=1 for exactly this cycle; go to ISSUE if `StartxSI`, else IDLE.
- `StartxSI` in ISSUE/DRAIN is ignored; no queuing.
- ISSUE:
  - `RndReqxSO`=1.
  - `SboxInxDO` = byte[cnt] of every share.
  - On an edge with `RndValidxDI`=1, push {valid=1, tag=cnt} into a LATENCY-deep shift pipe and increment the 5-bit counter.
  - With `RndValidxDI`=0, push a bubble (valid=0); cnt holds and the same byte stays presented.
- The pipe shifts every cycle regardless of state. When its output entry is valid, `SboxOutxDI` is written into byte[tag] of all shares on that edge.
- Count of written bytes: 5 bits, terminal value 16; DRAIN→DONE requires count=16.
- Bytes not yet written hold their input value; `DataxDO` is final only at the `DonexSO` cycle and holds until the next accepted start.
- Reset asserted mid-operation clears everything immediately. Results still in the S-box pipeline are discarded because the valid pipe is cleared.

## Timing

- `StartxSI` is high in cycle 0 and accepted at the end of cycle 0.
- With `RndValidxDI` tied 1:
  - Byte k is issued in cycle 1+k.
  - Its result is written at the end of cycle 1+k+LATENCY.
  - `DonexSO`=1 in cycle 17+LATENCY (cycle 22 for LATENCY=5).
- Each cycle with `RndValidxDI`=0 during ISSUE delays `DonexSO` by exactly one cycle.
- `BusyxSO` is high in cycles 1 .. 16+LATENCY; it is low in the `DonexSO` cycle.
- Back-to-back: `StartxSI` in the DONE cycle means the first byte of the next layer issues in the following cycle.

## Configuration

- `SBOX_IDLE_ZERO_EN`:
  - Defined: `SboxInxDO` is forced to all-zero in every cycle without an issue, i.e. when not in ISSUE or when `RndValidxDI`=0. This prevents stale shares recombining in the S-box during bubbles.
  - Undefined: `SboxInxDO` always shows byte[cnt], with cnt saturated at 15 outside ISSUE. The S-box discards these values because they carry no valid tag.
  - Timing and results are identical in both cases.

## Test plan

- SHARES=2, share0=0x00..0F, share1=0, `RndValidxDI`=1, start → `DonexSO` in cycle 22; unmasked `DataxDO` bytes = 0x63,0x7C,0x77,0x7B,…,0x76.
- Random shares of unmasked 0x53 in every byte, `RndValidxDI` toggling 1,0,1,0 → every unmasked output byte = 0xED; `DonexSO` delayed by the number of 0-cycles (16 → cycle 38).
- `StartxSI` pulsed again in cycle 5 → ignored, single `DonexSO`; second start in the DONE cycle → byte 0 issued the next cycle, second `DonexSO` 22 cycles after that.
- `RstxBI` low in cycle 10 (asynchronous, mid-clock) → outputs return to reset values immediately; no `DonexSO`; new start afterwards completes correctly with no stale write-back.
- SHARES=4, input 0x00 everywhere → unmasked output 0x63 in all 16 bytes.
- With `SBOX_IDLE_ZERO_EN` defined: `SboxInxDO`=0 in every non-issue cycle; results match the run without the macro bit-for-bit.
